// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32 control unit.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_TRAP      = 4'd11
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ITYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_RS1   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_RS2   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  // All per-step control signals, produced together by the decode block.
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  // True for the opcodes the core actually implements.
  function automatic logic is_known_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the controller and the datapath/memory port.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_read, mem_write, iord, ir_write, pc_write,
           pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
           reg_write, mem_to_reg
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_read, mem_write, iord, ir_write, pc_write,
           pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
           reg_write, mem_to_reg
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// State (+mem_ready in FETCH) to control-signal decode; purely combinational.
module multicycle_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control word; everything not set for a state stays 0.
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.iord      = 1'b0;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        // IR and PC only load on the cycle memory actually returns the word
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a = SRC_A_OLDPC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALUOP_ITYPE;
      end
      S_ALU_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = SRC_A_RS1;
        ctrl.alu_src_b     = SRC_B_RS2;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      default: ; // IDLE, TRAP: all zero
    endcase
    ctrl.mem_req = ctrl.mem_read | ctrl.mem_write;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 controller: state register, next-state logic, retire counter.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    ctrl_bus,
  output logic                 illegal_o,
  output logic [CNT_W-1:0]     instret_o,
  output logic [3:0]           state_o
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;
  ctrl_t            ctrl;

  multicycle_ctrl_decode u_decode (
    .state     (state_reg),
    .mem_ready (ctrl_bus.mem_ready),
    .ctrl      (ctrl)
  );

  // State register; reset drops any in-flight instruction back to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state selection; opcode is only looked at in DECODE and MEM_ADDR.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:      state_next = S_FETCH;
      S_FETCH:     if (ctrl_bus.mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        unique case (ctrl_bus.opcode)
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          default:      state_next = ILLEGAL_HALT ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_next = (ctrl_bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (ctrl_bus.mem_ready) state_next = S_MEM_WB;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: if (ctrl_bus.mem_ready) state_next = S_FETCH;
      S_EXEC_R:    state_next = S_ALU_WB;
      S_EXEC_I:    state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_BRANCH:    state_next = S_FETCH;
      S_TRAP:      state_next = S_TRAP;
      default:     state_next = S_IDLE;
    endcase
  end

  // An instruction retires on its last cycle; a stalled store retires when accepted.
  always_comb begin
    retire = 1'b0;
    unique case (state_reg)
      S_ALU_WB, S_MEM_WB, S_BRANCH: retire = 1'b1;
      S_MEM_WRITE:                  retire = ctrl_bus.mem_ready;
      default:                      retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n)      instret_reg <= '0;
    else if (retire) instret_reg <= instret_reg + 1'b1;
  end

  assign ctrl_bus.mem_req       = ctrl.mem_req;
  assign ctrl_bus.mem_read      = ctrl.mem_read;
  assign ctrl_bus.mem_write     = ctrl.mem_write;
  assign ctrl_bus.iord          = ctrl.iord;
  assign ctrl_bus.ir_write      = ctrl.ir_write;
  assign ctrl_bus.pc_write      = ctrl.pc_write;
  assign ctrl_bus.pc_write_cond = ctrl.pc_write_cond;
  assign ctrl_bus.pc_source     = ctrl.pc_source;
  assign ctrl_bus.alu_src_a     = ctrl.alu_src_a;
  assign ctrl_bus.alu_src_b     = ctrl.alu_src_b;
  assign ctrl_bus.alu_op        = ctrl.alu_op;
  assign ctrl_bus.reg_write     = ctrl.reg_write;
  assign ctrl_bus.mem_to_reg    = ctrl.mem_to_reg;

  assign illegal_o = (state_reg == S_TRAP);
  assign instret_o = instret_reg;
  assign state_o   = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl using a per-cycle expectation queue.
module tb_multicycle_ctrl;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LW_OP  = 7'b0000011;
  localparam logic [6:0] SW_OP  = 7'b0100011;
  localparam logic [6:0] BEQ_OP = 7'b1100011;
  localparam logic [6:0] BAD_OP = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ill1, ill2;
  logic [31:0] ret1;
  logic [1:0]  ret2;
  logic [3:0]  st1, st2;

  multicycle_ctrl_if if1 ();
  multicycle_ctrl_if if2 ();

  multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ctrl_bus(if1.master),
    .illegal_o(ill1), .instret_o(ret1), .state_o(st1)
  );

  // Second copy: illegal opcodes are NOPs, and a 2-bit counter exercises wrap
  multicycle_ctrl #(.CNT_W(2), .ILLEGAL_HALT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .ctrl_bus(if2.master),
    .illegal_o(ill2), .instret_o(ret2), .state_o(st2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
  } vec_t;

  typedef struct {
    int    st;
    vec_t  ctrl;
    int    ret;
    logic  ill;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_ret  = 0;
  int   exp_st2  = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    else
      n_pass++;
  endtask

  // Expected control word, written straight from the per-state output table.
  function automatic vec_t exp_ctrl(input int st, input logic rdy);
    vec_t v;
    v = '0;
    case (st)
      1:  begin v.mem_read = 1; v.alu_src_b = 2'b01; v.alu_op = 2'b11;
                v.ir_write = rdy; v.pc_write = rdy; end
      2:  begin v.alu_src_a = 2'b10; v.alu_src_b = 2'b10; v.alu_op = 2'b11; end
      3:  begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.alu_op = 2'b11; end
      4:  begin v.mem_read = 1; v.iord = 1; end
      5:  begin v.reg_write = 1; v.mem_to_reg = 1; end
      6:  begin v.mem_write = 1; v.iord = 1; end
      7:  begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b00; v.alu_op = 2'b10; end
      8:  begin v.alu_src_a = 2'b01; v.alu_src_b = 2'b10; v.alu_op = 2'b00; end
      9:  begin v.reg_write = 1; end
      10: begin v.alu_src_a = 2'b01; v.alu_op = 2'b01; v.pc_write_cond = 1;
                v.pc_source = 2'b01; end
      default: v = '0;
    endcase
    v.mem_req = v.mem_read | v.mem_write;
    return v;
  endfunction

  function automatic vec_t obs_ctrl();
    vec_t v;
    v = {if1.mem_req, if1.mem_read, if1.mem_write, if1.iord, if1.ir_write,
         if1.pc_write, if1.pc_write_cond, if1.pc_source, if1.alu_src_a,
         if1.alu_src_b, if1.alu_op, if1.reg_write, if1.mem_to_reg};
    return v;
  endfunction

  // One clock: drive inputs, queue the expectation, compare at the falling edge.
  task automatic cyc(input logic [6:0] op, input logic rdy, input logic rstn,
                     input int st, input bit retire);
    exp_t e;
    exp_t got;
    if1.opcode = op;     if2.opcode = op;
    if1.mem_ready = rdy; if2.mem_ready = rdy;
    rst_n = rstn;
    e.st = st; e.ctrl = exp_ctrl(st, rdy); e.ret = exp_ret; e.ill = (st == 11);
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check($sformatf("state(exp %0d)", got.st), {28'd0, st1}, got.st);
    check($sformatf("ctrl@%0d", got.st), {15'd0, obs_ctrl()}, {15'd0, got.ctrl});
    check($sformatf("instret@%0d", got.st), ret1, got.ret);
    check($sformatf("illegal@%0d", got.st), {31'd0, ill1}, {31'd0, got.ill});
    if (exp_st2 >= 0) begin
      check("dut2 state", {28'd0, st2}, exp_st2);
      check("dut2 instret", {30'd0, ret2}, exp_ret % 4);
    end
    $display("cycle op=%b rdy=%b rst_n=%b state=%0d instret=%0d", op, rdy, rstn, st1, ret1);
    if (retire) exp_ret++;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    if1.opcode = '0; if2.opcode = '0;
    if1.mem_ready = 1'b0; if2.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then an R-type aborted by reset in EXEC_R
    cyc(7'd0,   1'b1, 1'b1, 0, 0);
    cyc(7'd0,   1'b1, 1'b1, 1, 0);
    cyc(R_OP,   1'b0, 1'b1, 2, 0);
    cyc(R_OP,   1'b0, 1'b0, 7, 0);
    exp_ret = 0;
    cyc(R_OP,   1'b1, 1'b0, 0, 0);
    cyc(R_OP,   1'b1, 1'b1, 0, 0);

    // R-type, zero-wait memory; mem_ready high outside memory states is ignored
    cyc(7'd0,   1'b1, 1'b1, 1, 0);
    cyc(R_OP,   1'b1, 1'b1, 2, 0);
    cyc(R_OP,   1'b1, 1'b1, 7, 0);
    cyc(R_OP,   1'b1, 1'b1, 9, 1);

    // I-type ALU
    cyc(7'd0,   1'b1, 1'b1, 1, 0);
    cyc(I_OP,   1'b0, 1'b1, 2, 0);
    cyc(I_OP,   1'b0, 1'b1, 8, 0);
    cyc(I_OP,   1'b0, 1'b1, 9, 1);

    // LW with three wait cycles in MEM_READ: 8 cycles total
    cyc(7'd0,   1'b1, 1'b1, 1, 0);
    cyc(LW_OP,  1'b0, 1'b1, 2, 0);
    cyc(LW_OP,  1'b0, 1'b1, 3, 0);
    for (int i = 0; i < 3; i++) cyc(LW_OP, 1'b0, 1'b1, 4, 0);
    cyc(LW_OP,  1'b1, 1'b1, 4, 0);
    cyc(LW_OP,  1'b0, 1'b1, 5, 1);

    // SW with a fetch wait and a store wait; retires on the accepted cycle
    cyc(7'd0,   1'b0, 1'b1, 1, 0);
    cyc(7'd0,   1'b1, 1'b1, 1, 0);
    cyc(SW_OP,  1'b0, 1'b1, 2, 0);
    cyc(SW_OP,  1'b0, 1'b1, 3, 0);
    cyc(SW_OP,  1'b0, 1'b1, 6, 0);
    cyc(SW_OP,  1'b1, 1'b1, 6, 1);

    // BEQ: three cycles back to FETCH
    cyc(7'd0,   1'b1, 1'b1, 1, 0);
    cyc(BEQ_OP, 1'b1, 1'b1, 2, 0);
    cyc(BEQ_OP, 1'b1, 1'b1, 10, 1);

    // Illegal opcode: dut1 traps, dut2 returns to FETCH without retiring
    exp_st2 = 1;
    cyc(7'd0,   1'b1, 1'b1, 1, 0);
    exp_st2 = 2;
    cyc(BAD_OP, 1'b0, 1'b1, 2, 0);
    exp_st2 = 1;
    cyc(BAD_OP, 1'b0, 1'b1, 11, 0);
    exp_st2 = -1;
    for (int i = 0; i < 19; i++)
      cyc(R_OP, 1'($urandom_range(0, 1)), 1'b1, 11, 0);

    // Reset is the only way out of TRAP
    cyc(R_OP,   1'b1, 1'b0, 11, 0);
    exp_ret = 0;
    cyc(R_OP,   1'b1, 1'b1, 0, 0);
    cyc(R_OP,   1'b1, 1'b1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
